prefetcher_data_burst: RTL and testbench
========================================

// Module: prefetcher_data_burst
// PURPOSE
//  Next-generation prefetch data queue between the prefetch controller and the DDR/NVDLA AXI read paths.
//  Circular queue of address blocks. Each block holds a variable-length burst of up to 2^LOG_MAX_BEATS data beats.
//  Supports per-request burst length, beat streaming to NVDLA before the burst completes, and promise replay (promiseCnt>1).
//  Instantiated once per AXI read ID by the prefetcher top level.
// PARAMETERS
//  LOG_QUEUE_SIZE        4   queue depth = 2^LOG_QUEUE_SIZE blocks
//  LOG_BLOCK_DATA_BYTES  3   beat width = 8*2^x bits (DATA_BITS)
//  LOG_MAX_BEATS         2   max beats per block = 2^x
//  ADDR_BITS             64  address width
//  PROMISE_WIDTH         3   per-block promise counter width
//  BURST_LEN_WIDTH       4   reqBurstLen width (AXI len encoding, beats-1)
//  STAT_WIDTH            16  statistics counter width (PREFETCH_STATS_EN only)
// PORTS
//  clk                   in   1                clock
//  reset                 in   1                synchronous, active-high
//  reqAddr               in   ADDR_BITS        request address (opcodes 1,2)
//  reqBurstLen           in   BURST_LEN_WIDTH  beats-1 of the request (opcodes 1,2)
//  reqData               in   DATA_BITS        DDR read beat (opcode 3)
//  reqLast               in   1                last beat of DDR burst (opcode 3)
//  reqOpcode             in   3                0 NOP, 1 readReqPref, 2 readReqMaster, 3 readDataSlave, 4 readDataPromise
//  crs_almostFullSpacer  in   LOG_QUEUE_SIZE   almostFull threshold distance
//  respData              out  DATA_BITS        beat offered to NVDLA
//  respLast              out  1                respData is the final beat of the head burst
//  pr_r_valid            out  1                respData is valid
//  addrHit               out  1                reqAddr matches a valid block
//  prefetchReqCnt        out  LOG_QUEUE_SIZE+1 count of blocks with prefetchReq=1
//  almostFull            out  1                validCnt >= 2^LOG_QUEUE_SIZE - crs_almostFullSpacer
//  errorCode             out  3                registered status of the previous cycle's op
//  hasOutstanding        out  1                some valid block still awaits beats
// BEHAVIOUR
//  - Reset: validVec, pointers, counts and errorCode cleared. All outputs read 0 the cycle after reset. Reset overrides any opcode.
//  - Block state: addr, burstLen, beatCnt (beats written), readBeat, promiseCnt, prefetchReq, dataDone.
//  - Combinational outputs:
//    - addrHit: full-address compare across valid blocks; the youngest match is selected.
//    - pr_r_valid: head valid && promiseCnt>0 && readBeat<beatCnt.
//    - respData: head beat[readBeat].
//    - respLast: readBeat==burstLen.
//  - State updates on rising clk: one opcode per cycle. Pointers wrap mod 2^LOG_QUEUE_SIZE. full = validCnt==2^LOG_QUEUE_SIZE.
//  - op1, hit: no change, err 0. Miss and not full: push at tail (prefetchReq=1, promiseCnt=0, burstLen latched). Full: err 1, no change.
//  - op2, hit: matched block promiseCnt++ and prefetchReq=0. Promise at max saturates: err 4, no change.
//  - op2, miss: push with promiseCnt=1, prefetchReq=0. Full: err 1, no change.
//  - op3: target is the oldest valid block with dataDone=0, via fillPtr.
//    - The beat is written at beatCnt and beatCnt increments. reqLast sets dataDone and advances fillPtr.
//    - reqLast with beatCnt!=burstLen, or a beat beyond burstLen (dropped): err 5.
//    - No target: err 2, no change.
//  - op4 with pr_r_valid: readBeat increments.
//    - On the respLast beat: readBeat=0 and promiseCnt decrements. If promiseCnt reaches 0, pop head; otherwise the burst replays.
//    - op4 without pr_r_valid: err 3.
//  - Opcodes 5-7: err 6, no change. NOP: err 0.
//  - Beats stream out while the same block is still filling (op3 and op4 alternate freely).
//  - A head block with promiseCnt==0 blocks the output until claimed by op2.
//  - reqBurstLen >= 2^LOG_MAX_BEATS on op1/op2: err 5, no push.
// CONFIGURATION
//  PREFETCH_STATS_EN defined: adds outputs statHitCnt and statMissCnt (out, STAT_WIDTH).
//    - statHitCnt increments on op2 hit; statMissCnt increments on op2 miss.
//    - Both saturate at all-ones and clear on reset.
//  PREFETCH_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. reset; three op2 misses 0x100/0x101/0x102, len 1 -> addrHit=0 each; hasOutstanding=1; pr_r_valid=0; prefetchReqCnt=0.
//  2. op3 beats 0x10,0x20(last) -> pr_r_valid=1, respData=0x10; op4 -> respData=0x20, respLast=1; op4 -> head pops.
//  3. op1 0x200, then op2 0x200 twice, then 2 beats -> prefetchReqCnt 1->0; burst read twice via op4, then block popped.
//  4. fill 16 blocks -> almostFull=1 from validCnt 14 (spacer 2); 17th op1 -> errorCode=1, validCnt stays 16; push after pop wraps tail to 0.
//  5. op4 on empty -> errorCode=3; op3 with no outstanding -> 2; reqLast on beat 0 of len-1 burst -> 5; opcode 6 -> 6.
//  6. reset asserted mid-burst with op3 -> next cycle pr_r_valid=0, hasOutstanding=0, errorCode=0; stats (if enabled) = 0.

Source files
------------

// File: rtl/prefetcher_data_burst.sv
// prefetcher_data_burst: circular queue of burst blocks feeding NVDLA with streaming, promise replay; PREFETCH_STATS_EN adds hit/miss counters
module prefetcher_data_burst #(
  parameter int LOG_QUEUE_SIZE       = 4,
  parameter int LOG_BLOCK_DATA_BYTES = 3,
  parameter int LOG_MAX_BEATS        = 2,
  parameter int ADDR_BITS            = 64,
  parameter int PROMISE_WIDTH        = 3,
  parameter int BURST_LEN_WIDTH      = 4
`ifdef PREFETCH_STATS_EN
  , parameter int STAT_WIDTH         = 16
`endif
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [ADDR_BITS-1:0]                 reqAddr,
  input  logic [BURST_LEN_WIDTH-1:0]           reqBurstLen,
  input  logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0] reqData,
  input  logic                                 reqLast,
  input  logic [2:0]                           reqOpcode,
  input  logic [LOG_QUEUE_SIZE-1:0]            crs_almostFullSpacer,
  output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0] respData,
  output logic                                 respLast,
  output logic                                 pr_r_valid,
  output logic                                 addrHit,
  output logic [LOG_QUEUE_SIZE:0]              prefetchReqCnt,
  output logic                                 almostFull,
  output logic [2:0]                           errorCode,
  output logic                                 hasOutstanding
`ifdef PREFETCH_STATS_EN
  , output logic [STAT_WIDTH-1:0]              statHitCnt,
  output logic [STAT_WIDTH-1:0]                statMissCnt
`endif
);
  localparam int LQ = LOG_QUEUE_SIZE;
  localparam int LM = LOG_MAX_BEATS;
  localparam int Q  = 1 << LQ;
  localparam int MB = 1 << LM;
  localparam int DW = 8 << LOG_BLOCK_DATA_BYTES;
  logic [ADDR_BITS-1:0]     addr_q     [Q];
  logic [LM-1:0]            len_q      [Q];
  logic [LM:0]              beat_cnt_q [Q];
  logic [LM-1:0]            rd_beat_q  [Q];
  logic [PROMISE_WIDTH-1:0] prom_q     [Q];
  logic [DW-1:0]            data_q     [Q][MB];
  logic [Q-1:0]             valid_q, pref_q, done_q;
  logic [LQ-1:0]            head_q, head_d, tail_q, tail_d, hit_idx, fill_idx;
  logic [LQ:0]              cnt_q, cnt_d;
  logic [2:0]               err_q, err_d;
  logic                     hit, fill_ok, full, over, last, pop, push, inc, wr, rd, is_op2;
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    fill_ok = 1'b0;
    fill_idx = '0;
    prefetchReqCnt = '0;
    for (int i = 0; i < Q; i++) begin
      if (valid_q[head_q + LQ'(i)] && addr_q[head_q + LQ'(i)] == reqAddr) begin
        hit = 1'b1;
        hit_idx = head_q + LQ'(i);
      end
      prefetchReqCnt = prefetchReqCnt + (LQ+1)'(valid_q[i] & pref_q[i]);
    end
    // scanning youngest to oldest leaves the oldest unfinished block selected
    for (int i = Q - 1; i >= 0; i--)
      if (valid_q[head_q + LQ'(i)] && !done_q[head_q + LQ'(i)]) begin
        fill_ok = 1'b1;
        fill_idx = head_q + LQ'(i);
      end
  end
  assign addrHit        = hit;
  assign hasOutstanding = fill_ok;
  assign full           = cnt_q == (LQ+1)'(Q);
  assign almostFull     = cnt_q >= (LQ+1)'(Q) - {1'b0, crs_almostFullSpacer};
  assign errorCode      = err_q;
  assign is_op2         = reqOpcode == 3'd2;
  assign pr_r_valid     = valid_q[head_q] && prom_q[head_q] != '0 && {1'b0, rd_beat_q[head_q]} < beat_cnt_q[head_q];
  assign last           = rd_beat_q[head_q] == len_q[head_q];
  assign respLast       = pr_r_valid && last;
  assign respData       = pr_r_valid ? data_q[head_q][rd_beat_q[head_q]] : '0;
  assign over           = beat_cnt_q[fill_idx] > {1'b0, len_q[fill_idx]};
  assign pop            = rd && last && prom_q[head_q] == PROMISE_WIDTH'(1);
  assign head_d         = head_q + LQ'(pop);
  assign tail_d         = tail_q + LQ'(push);
  assign cnt_d          = cnt_q + (LQ+1)'(push) - (LQ+1)'(pop);
  always_comb begin
    err_d = 3'd0;
    push = 1'b0;
    inc = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    case (reqOpcode)
      3'd0: ;
      3'd1, 3'd2:
        if (hit) begin
          if (is_op2 && &prom_q[hit_idx]) err_d = 3'd4;
          else inc = is_op2;
        end
        else if (32'(reqBurstLen) >= MB) err_d = 3'd5;
        else if (full) err_d = 3'd1;
        else push = 1'b1;
      3'd3: begin
        wr = fill_ok;
        err_d = !fill_ok ? 3'd2 : (over || (reqLast && beat_cnt_q[fill_idx] != {1'b0, len_q[fill_idx]})) ? 3'd5 : 3'd0;
      end
      3'd4: begin
        rd = pr_r_valid;
        err_d = pr_r_valid ? 3'd0 : 3'd3;
      end
      default: err_d = 3'd6;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      err_q <= err_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        addr_q[tail_q] <= reqAddr;
        len_q[tail_q] <= reqBurstLen[LM-1:0];
        beat_cnt_q[tail_q] <= '0;
        rd_beat_q[tail_q] <= '0;
        prom_q[tail_q] <= PROMISE_WIDTH'(is_op2);
        pref_q[tail_q] <= !is_op2;
        done_q[tail_q] <= 1'b0;
      end
      if (inc) begin
        prom_q[hit_idx] <= prom_q[hit_idx] + 1'b1;
        pref_q[hit_idx] <= 1'b0;
      end
      if (wr) begin
        if (!over) begin
          data_q[fill_idx][beat_cnt_q[fill_idx][LM-1:0]] <= reqData;
          beat_cnt_q[fill_idx] <= beat_cnt_q[fill_idx] + 1'b1;
        end
        if (reqLast) done_q[fill_idx] <= 1'b1;
      end
      if (rd) begin
        rd_beat_q[head_q] <= last ? '0 : rd_beat_q[head_q] + 1'b1;
        if (last) prom_q[head_q] <= prom_q[head_q] - 1'b1;
        if (pop) valid_q[head_q] <= 1'b0;
      end
    end
  end
`ifdef PREFETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      statHitCnt <= '0;
      statMissCnt <= '0;
    end else if (is_op2) begin
      if (hit && !(&statHitCnt)) statHitCnt <= statHitCnt + 1'b1;
      if (!hit && !(&statMissCnt)) statMissCnt <= statMissCnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_prefetcher_data_burst.sv
// tb_prefetcher_data_burst: directed scenarios plus random ops checked each cycle against a queue-of-blocks model
module tb_prefetcher_data_burst;
  logic        clk = 1'b0, reset = 1'b1, reqLast = 1'b0, chk_en = 1'b0;
  logic [63:0] reqAddr = '0, reqData = '0, respData;
  logic [3:0]  reqBurstLen = '0, crs_almostFullSpacer = 4'd2;
  logic [2:0]  reqOpcode = '0, errorCode;
  logic        respLast, pr_r_valid, addrHit, almostFull, hasOutstanding;
  logic [4:0]  prefetchReqCnt;
`ifdef PREFETCH_STATS_EN
  logic [15:0] statHitCnt, statMissCnt;
`endif
  int n_chk = 0, n_fail = 0;
  int err_m = 0, st_hit = 0, st_miss = 0;
  localparam int SMAX = 65535;

  typedef struct {
    logic [63:0] addr;
    int len, bc, rb, prom;
    bit pref, done;
    logic [63:0] data[4];
  } blk_t;
  blk_t mq[$];

  prefetcher_data_burst dut (
    .clk(clk), .reset(reset), .reqAddr(reqAddr), .reqBurstLen(reqBurstLen), .reqData(reqData),
    .reqLast(reqLast), .reqOpcode(reqOpcode), .crs_almostFullSpacer(crs_almostFullSpacer),
    .respData(respData), .respLast(respLast), .pr_r_valid(pr_r_valid), .addrHit(addrHit),
    .prefetchReqCnt(prefetchReqCnt), .almostFull(almostFull), .errorCode(errorCode),
    .hasOutstanding(hasOutstanding)
`ifdef PREFETCH_STATS_EN
    , .statHitCnt(statHitCnt), .statMissCnt(statMissCnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_pv();
    return mq.size() > 0 && mq[0].prom > 0 && mq[0].rb < mq[0].bc;
  endfunction

  // advance the model by one clock using the inputs currently applied
  task automatic model_apply();
    blk_t b;
    int hi, f;
    if (reset) begin
      mq.delete();
      err_m = 0; st_hit = 0; st_miss = 0;
      return;
    end
    err_m = 0;
    hi = -1;
    foreach (mq[i]) if (mq[i].addr == reqAddr) hi = i;
    case (reqOpcode)
      3'd1, 3'd2:
        if (hi >= 0) begin
          if (reqOpcode == 3'd2) begin
            if (st_hit < SMAX) st_hit++;
            b = mq[hi];
            if (b.prom == 7) err_m = 4;
            else begin b.prom++; b.pref = 0; mq[hi] = b; end
          end
        end else begin
          if (reqOpcode == 3'd2 && st_miss < SMAX) st_miss++;
          if (reqBurstLen >= 4) err_m = 5;
          else if (mq.size() == 16) err_m = 1;
          else begin
            b.addr = reqAddr; b.len = int'(reqBurstLen); b.bc = 0; b.rb = 0;
            b.prom = (reqOpcode == 3'd2) ? 1 : 0; b.pref = (reqOpcode == 3'd1); b.done = 0;
            foreach (b.data[k]) b.data[k] = '0;
            mq.push_back(b);
          end
        end
      3'd3: begin
        f = -1;
        for (int i = mq.size() - 1; i >= 0; i--) if (!mq[i].done) f = i;
        if (f < 0) err_m = 2;
        else begin
          b = mq[f];
          if (b.bc > b.len || (reqLast && b.bc != b.len)) err_m = 5;
          if (b.bc <= b.len) begin b.data[b.bc] = reqData; b.bc++; end
          if (reqLast) b.done = 1;
          mq[f] = b;
        end
      end
      3'd4:
        if (m_pv()) begin
          b = mq[0];
          if (b.rb == b.len) begin
            b.rb = 0; b.prom--;
            if (b.prom == 0) void'(mq.pop_front());
            else mq[0] = b;
          end else begin
            b.rb++; mq[0] = b;
          end
        end else err_m = 3;
      3'd0: ;
      default: err_m = 6;
    endcase
  endtask

  always @(negedge clk) begin : cmp
    bit ah, pv, ho;
    int pc;
    if (chk_en) begin
      ah = 0; ho = 0; pc = 0;
      foreach (mq[i]) begin
        if (mq[i].addr == reqAddr) ah = 1;
        if (!mq[i].done) ho = 1;
        if (mq[i].pref) pc++;
      end
      pv = m_pv();
      chk("addrHit", 64'(addrHit), 64'(ah));
      chk("pr_r_valid", 64'(pr_r_valid), 64'(pv));
      chk("respLast", 64'(respLast), 64'(pv && mq[0].rb == mq[0].len));
      if (pv) chk("respData", respData, mq[0].data[mq[0].rb]);
      chk("prefetchReqCnt", 64'(prefetchReqCnt), 64'(pc));
      chk("almostFull", 64'(almostFull), 64'(mq.size() >= 16 - int'(crs_almostFullSpacer)));
      chk("errorCode", 64'(errorCode), 64'(err_m));
      chk("hasOutstanding", 64'(hasOutstanding), 64'(ho));
`ifdef PREFETCH_STATS_EN
      chk("statHitCnt", 64'(statHitCnt), 64'(st_hit));
      chk("statMissCnt", 64'(statMissCnt), 64'(st_miss));
`endif
    end
  end

  task automatic step(input logic [2:0] op, input logic [63:0] a, input logic [3:0] l,
                      input logic [63:0] d, input logic lst, input logic rst);
    reqOpcode = op; reqAddr = a; reqBurstLen = l; reqData = d; reqLast = lst; reset = rst;
    @(posedge clk);
    model_apply();
    #1;
  endtask

  task automatic do_reset();
    step(3'd0, 64'd0, 4'd0, 64'd0, 1'b0, 1'b1);
    step(3'd0, 64'd0, 4'd0, 64'd0, 1'b0, 1'b0);
  endtask

  int r;
  initial begin
    step(3'd0, 64'd0, 4'd0, 64'd0, 1'b0, 1'b1);
    chk_en = 1'b1;
    step(3'd0, 64'd0, 4'd0, 64'd0, 1'b0, 1'b0);
    chk("reset_err", 64'(errorCode), 64'd0);
    chk("reset_valid", 64'(pr_r_valid), 64'd0);
    // three promised misses
    for (int k = 0; k < 3; k++) step(3'd2, 64'h100 + 64'(k), 4'd1, 64'd0, 1'b0, 1'b0);
    chk("t1_outstanding", 64'(hasOutstanding), 64'd1);
    chk("t1_valid", 64'(pr_r_valid), 64'd0);
    chk("t1_prefcnt", 64'(prefetchReqCnt), 64'd0);
    step(3'd0, 64'h101, 4'd0, 64'd0, 1'b0, 1'b0);
    chk("t1_hit", 64'(addrHit), 64'd1);
    // stream two beats then drain
    step(3'd3, 64'd0, 4'd0, 64'h10, 1'b0, 1'b0);
    chk("t2_valid", 64'(pr_r_valid), 64'd1);
    chk("t2_data0", respData, 64'h10);
    step(3'd3, 64'd0, 4'd0, 64'h20, 1'b1, 1'b0);
    step(3'd4, 64'd0, 4'd0, 64'd0, 1'b0, 1'b0);
    chk("t2_data1", respData, 64'h20);
    chk("t2_last", 64'(respLast), 64'd1);
    step(3'd4, 64'd0, 4'd0, 64'd0, 1'b0, 1'b0);
    chk("t2_popped", 64'(pr_r_valid), 64'd0);
    // prefetch then two promises, burst replayed
    do_reset();
    step(3'd1, 64'h200, 4'd1, 64'd0, 1'b0, 1'b0);
    chk("t3_pref1", 64'(prefetchReqCnt), 64'd1);
    step(3'd2, 64'h200, 4'd1, 64'd0, 1'b0, 1'b0);
    step(3'd2, 64'h200, 4'd1, 64'd0, 1'b0, 1'b0);
    chk("t3_pref0", 64'(prefetchReqCnt), 64'd0);
    step(3'd3, 64'd0, 4'd0, 64'hA, 1'b0, 1'b0);
    step(3'd3, 64'd0, 4'd0, 64'hB, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(3'd4, 64'd0, 4'd0, 64'd0, 1'b0, 1'b0);
    chk("t3_replay_data", respData, 64'hB);
    chk("t3_replay_last", 64'(respLast), 64'd1);
    step(3'd4, 64'd0, 4'd0, 64'd0, 1'b0, 1'b0);
    chk("t3_gone_valid", 64'(pr_r_valid), 64'd0);
    chk("t3_gone_out", 64'(hasOutstanding), 64'd0);
    // fill, overflow, pop and wrap
    do_reset();
    crs_almostFullSpacer = 4'd2;
    for (int k = 0; k < 16; k++) begin
      step(3'd1, 64'h400 + 64'(k), 4'd0, 64'd0, 1'b0, 1'b0);
      if (k == 12) chk("t4_af13", 64'(almostFull), 64'd0);
      if (k == 13) chk("t4_af14", 64'(almostFull), 64'd1);
    end
    step(3'd1, 64'h4FF, 4'd0, 64'd0, 1'b0, 1'b0);
    chk("t4_full_err", 64'(errorCode), 64'd1);
    step(3'd2, 64'h400, 4'd0, 64'd0, 1'b0, 1'b0);
    step(3'd3, 64'd0, 4'd0, 64'h55, 1'b1, 1'b0);
    chk("t4_head_valid", 64'(pr_r_valid), 64'd1);
    step(3'd4, 64'd0, 4'd0, 64'd0, 1'b0, 1'b0);
    step(3'd1, 64'h4F0, 4'd0, 64'd0, 1'b0, 1'b0);
    chk("t4_wrap_err", 64'(errorCode), 64'd0);
    step(3'd1, 64'h4F1, 4'd0, 64'd0, 1'b0, 1'b0);
    chk("t4_refull_err", 64'(errorCode), 64'd1);
    // error codes
    do_reset();
    step(3'd4, 64'd0, 4'd0, 64'd0, 1'b0, 1'b0);
    chk("t5_err3", 64'(errorCode), 64'd3);
    step(3'd3, 64'd0, 4'd0, 64'd0, 1'b0, 1'b0);
    chk("t5_err2", 64'(errorCode), 64'd2);
    step(3'd1, 64'h510, 4'd4, 64'd0, 1'b0, 1'b0);
    chk("t5_badlen", 64'(errorCode), 64'd5);
    step(3'd2, 64'h500, 4'd1, 64'd0, 1'b0, 1'b0);
    step(3'd3, 64'd0, 4'd0, 64'h77, 1'b1, 1'b0);
    chk("t5_earlylast", 64'(errorCode), 64'd5);
    step(3'd6, 64'd0, 4'd0, 64'd0, 1'b0, 1'b0);
    chk("t5_err6", 64'(errorCode), 64'd6);
    // reset during a burst
    do_reset();
    step(3'd2, 64'h600, 4'd3, 64'd0, 1'b0, 1'b0);
    step(3'd3, 64'd0, 4'd0, 64'h1, 1'b0, 1'b0);
    step(3'd3, 64'd0, 4'd0, 64'h2, 1'b0, 1'b1);
    chk("t6_valid", 64'(pr_r_valid), 64'd0);
    chk("t6_out", 64'(hasOutstanding), 64'd0);
    chk("t6_err", 64'(errorCode), 64'd0);
`ifdef PREFETCH_STATS_EN
    chk("t6_stat_hit", 64'(statHitCnt), 64'd0);
    chk("t6_stat_miss", 64'(statMissCnt), 64'd0);
`endif
    // randomized traffic over a small address pool so hits, saturation and fullness all occur
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) crs_almostFullSpacer = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 99);
      step(r < 15 ? 3'd1 : r < 35 ? 3'd2 : r < 60 ? 3'd3 : r < 90 ? 3'd4 : r < 96 ? 3'd0 : 3'($urandom_range(5, 7)),
           64'h300 + 64'($urandom_range(0, 19)), 4'($urandom_range(0, 4)),
           {$urandom, $urandom}, $urandom_range(0, 2) == 0, $urandom_range(0, 399) == 0);
    end
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
